// File: rtl/ft_rx_checker_if.sv
// RX FIFO read port of the FT601 bridge: read strobe out, data and empty flag back.
// Standard (non-FWFT) FIFO: data is valid the cycle after the strobe.
interface ft_rx_checker_if;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;

    modport master (output rd_en, input rd_data, input rd_empty);
    modport slave  (input rd_en, output rd_data, output rd_empty);
endinterface

// File: rtl/ft_rx_checker.sv
// FT601 RX loopback checker: drains the RX FIFO and checks each word against the
// incrementing byte pattern {b+3,b+2,b+1,b}, b += 4 per word, reporting counts and first error.
module ft_rx_checker #(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic               rd_clk,
    input  logic               sys_rst,
    input  logic               ft_ready,
    input  logic               chk_clr,
    ft_rx_checker_if.master    fifo,
    output logic               locked,
    output logic [CNT_W-1:0]   words_cnt,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               err_flag,
    output logic [31:0]        first_err_data,
    output logic [31:0]        first_err_exp
);

    typedef enum logic {HUNT = 1'b0, CHECK = 1'b1} state_t;

    function automatic logic [31:0] exp_word(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        clr;
    logic        rd_vld_p1;
    logic [7:0]  exp_b;
    logic [31:0] exp_word_p1;
    logic        mism_p1;

    assign clr        = sys_rst | chk_clr;
    assign fifo.rd_en = ft_ready & ~fifo.rd_empty & ~clr;

    // ---- stage p0 -> p1: read strobe becomes data-valid
    always_ff @(posedge rd_clk) begin
        if (clr) rd_vld_p1 <= 1'b0;
        else     rd_vld_p1 <= fifo.rd_en;
    end

    // In HUNT the word seeds itself, so only its own low byte defines what it should be.
    always_comb begin
        exp_word_p1 = (state == HUNT) ? exp_word(fifo.rd_data[7:0]) : exp_word(exp_b);
        mism_p1     = (fifo.rd_data != exp_word_p1);
    end

    always_ff @(posedge rd_clk) begin
        if (clr) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rd_vld_p1 && state == HUNT && !mism_p1) state_nxt = CHECK;
    end

    always_comb begin
        locked = (state == CHECK);
    end

    // ---- stage p1 -> p2: compare result folded into status registers
    always_ff @(posedge rd_clk) begin
        if (clr) begin
            exp_b          <= 8'd0;
            words_cnt      <= '0;
            err_cnt        <= '0;
            err_flag       <= 1'b0;
            first_err_data <= 32'd0;
            first_err_exp  <= 32'd0;
        end else if (rd_vld_p1) begin
            words_cnt <= words_cnt + CNT_W'(1);
            if (!mism_p1) begin
                exp_b <= (state == HUNT) ? fifo.rd_data[7:0] + 8'd4 : exp_b + 8'd4;
            end else begin
                err_cnt  <= sat_inc(err_cnt);
                err_flag <= 1'b1;
                if (!err_flag) begin
                    first_err_data <= fifo.rd_data;
                    first_err_exp  <= exp_word_p1;
                end
                // Resync on the received word so a dropped word costs one error.
                if (state == CHECK) exp_b <= fifo.rd_data[7:0] + 8'd4;
            end
        end
    end

endmodule
